// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the requesters/TX driver side and the TX arbiter.
// Signal names keep their i_/o_ prefixes as seen from the arbiter.
interface tx_arbiter_if #(
  parameter int NBITS  = 8,
  parameter int NREQ   = 4,
  parameter int NBYTES = 4
);
  logic [NREQ-1:0]              i_req;
  logic [NREQ*NBYTES*NBITS-1:0] i_data;
  logic [NREQ-1:0]              o_grant;
  logic [NREQ-1:0]              o_ack;
  logic                         o_busy;
  logic                         o_tx_start;
  logic [NBITS-1:0]             o_tx_data;
  logic                         i_tx_done;

  modport master (
    output i_req, i_data, i_tx_done,
    input  o_grant, o_ack, o_busy, o_tx_start, o_tx_data
  );

  modport slave (
    input  i_req, i_data, i_tx_done,
    output o_grant, o_ack, o_busy, o_tx_start, o_tx_data
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one UART TX, sending
// each granted word LSB byte first and acking the owner when it is done.
//
// state | meaning
// IDLE  | no owner; arbitrate on any pending request
// START | one-cycle tx start pulse with the current byte
// WAIT  | byte in flight; wait for the TX end-of-frame pulse
// ACK   | one-cycle ack to owner; owner becomes round-robin "last"
module tx_arbiter #(
  parameter int NBITS  = 8,
  parameter int NREQ   = 4,
  parameter int NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  tx_arbiter_if.slave bus
);
  localparam int WORDW = NBYTES * NBITS;
  localparam int IW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_BYTE = IW'(NBYTES - 1);
  localparam logic [LW-1:0] LAST_REQ  = LW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [NBITS-1:0]  data_q, data_d;
  logic [IW-1:0]     idx_q, idx_d, idx_next;
  logic [LW-1:0]     own_q, own_d;
  logic [LW-1:0]     last_q, last_d;
  logic [WORDW-1:0]  word_q, word_d, pick_word;

  logic              pick_found;
  logic [LW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_onehot;

  // First pending requester after the previous owner, wrapping around.
  always_comb begin
    int cand;
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!pick_found && bus.i_req[LW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = LW'(cand);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      pick_onehot[k] = (pick_idx == LW'(k));
    end
  end

  assign pick_word = bus.i_data[pick_idx*WORDW +: WORDW];
  assign idx_next  = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    idx_d   = idx_q;
    own_d   = own_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = START;
          grant_d = pick_onehot;
          own_d   = pick_idx;
          word_d  = pick_word;
          idx_d   = '0;
          start_d = 1'b1;
          data_d  = pick_word[NBITS-1:0];
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_q == LAST_BYTE) begin
            state_d = ACK;
            ack_d   = grant_q;
          end else begin
            state_d = START;
            idx_d   = idx_next;
            start_d = 1'b1;
            data_d  = word_q[idx_next*NBITS +: NBITS];
          end
        end
      end
      ACK: begin
        state_d = IDLE;
        last_d  = own_q;
        grant_d = '0;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      own_q   <= '0;
      last_q  <= LAST_REQ;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      own_q   <= own_d;
      last_q  <= last_d;
      word_q  <= word_d;
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_ack      = ack_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_tx_start = start_q;
  assign bus.o_tx_data  = data_q;
endmodule
